sync_fifo_flags: RTL and testbench

- Single-clock, parametrised FIFO; the single-domain successor of the team's async FIFO.
- Buffers configuration words between the host-side register logic and the ICAP write sequencer.
- Adds an occupancy count, programmable almost-full and almost-empty thresholds, a selectable first-word-fall-through (FWFT) read mode, sticky overflow/underflow error flags, and a synchronous flush.

---
 rtl/sync_fifo_flags.sv | 88 ++++++++
 tb/tb_sync_fifo_flags.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// selectable FWFT read mode, sticky overflow/underflow flags and synchronous flush.
module sync_fifo_flags #(
    parameter int DATA_SIZE     = 32,
    parameter int ARRAY_SIZE    = 4,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 2,
    parameter int FWFT          = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_SIZE-1:0]  wdata,
    input  logic                  winc,
    input  logic                  rinc,
    output logic [DATA_SIZE-1:0]  rdata,
    output logic                  wfull,
    output logic                  rempty,
    output logic                  walmost_full,
    output logic                  ralmost_empty,
    output logic [ARRAY_SIZE:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                DEPTH   = 1 << ARRAY_SIZE;
    localparam logic [ARRAY_SIZE:0] DEPTH_C = (ARRAY_SIZE+1)'(DEPTH);
    localparam logic [ARRAY_SIZE:0] AF_C    = (ARRAY_SIZE+1)'(AFULL_THRESH);
    localparam logic [ARRAY_SIZE:0] AE_C    = (ARRAY_SIZE+1)'(AEMPTY_THRESH);

    logic [DATA_SIZE-1:0]  mem [DEPTH];
    logic [ARRAY_SIZE-1:0] waddr;
    logic [ARRAY_SIZE-1:0] raddr;
    logic                  wr_ok;
    logic                  rd_ok;

    // Flags depend only on the registered count, never on this cycle's requests.
    assign wfull         = (count == DEPTH_C);
    assign rempty        = (count == '0);
    assign walmost_full  = (count >= AF_C);
    assign ralmost_empty = (count <= AE_C);

    assign wr_ok = winc && !wfull;
    assign rd_ok = rinc && !rempty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waddr     <= '0;
            raddr     <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            waddr     <= '0;
            raddr     <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) waddr <= waddr + 1'b1;
            if (rd_ok) raddr <= raddr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (winc && wfull)  overflow  <= 1'b1;
            if (rinc && rempty) underflow <= 1'b1;
        end
    end

    // Storage is deliberately not reset; flush only drops the pending write.
    always_ff @(posedge clk) begin
        if (wr_ok && !flush) mem[waddr] <= wdata;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rdata = mem[raddr];
        end else begin : g_std
            always_ff @(posedge clk or posedge rst) begin
                if (rst)                 rdata <= '0;
                else if (rd_ok && !flush) rdata <= mem[raddr];
            end
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Scoreboard bench for sync_fifo_flags: a reference model tracks count, flags and
// a queue of written words; every cycle all DUT outputs are compared to the model.
module tb_sync_fifo_flags;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush, winc, rinc;
    logic [DW-1:0] wdata, rdata;
    logic          wfull, rempty, walmost_full, ralmost_empty, overflow, underflow;
    logic [AW:0]   count;

    logic          f_flush, f_winc, f_rinc;
    logic [DW-1:0] f_wdata, f_rdata;
    logic          f_wfull, f_rempty, f_walmost_full, f_ralmost_empty, f_overflow, f_underflow;
    logic [AW:0]   f_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] sb_q [$];
    int            m_count = 0;
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;
    logic [DW-1:0] m_rdata = '0;

    always #5 clk = ~clk;

    sync_fifo_flags #(.DATA_SIZE(DW), .ARRAY_SIZE(AW), .AFULL_THRESH(12),
                      .AEMPTY_THRESH(2), .FWFT(0)) dut (
        .clk(clk), .rst(rst), .flush(flush), .wdata(wdata), .winc(winc), .rinc(rinc),
        .rdata(rdata), .wfull(wfull), .rempty(rempty), .walmost_full(walmost_full),
        .ralmost_empty(ralmost_empty), .count(count), .overflow(overflow),
        .underflow(underflow)
    );

    sync_fifo_flags #(.DATA_SIZE(DW), .ARRAY_SIZE(AW), .AFULL_THRESH(12),
                      .AEMPTY_THRESH(2), .FWFT(1)) dut_f (
        .clk(clk), .rst(rst), .flush(f_flush), .wdata(f_wdata), .winc(f_winc), .rinc(f_rinc),
        .rdata(f_rdata), .wfull(f_wfull), .rempty(f_rempty), .walmost_full(f_walmost_full),
        .ralmost_empty(f_ralmost_empty), .count(f_count), .overflow(f_overflow),
        .underflow(f_underflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".count"},     32'(count),    32'(m_count));
        check({ctx, ".rempty"},    32'(rempty),   32'(m_count == 0));
        check({ctx, ".wfull"},     32'(wfull),    32'(m_count == 16));
        check({ctx, ".afull"},     32'(walmost_full),  32'(m_count >= 12));
        check({ctx, ".aempty"},    32'(ralmost_empty), 32'(m_count <= 2));
        check({ctx, ".overflow"},  32'(overflow),  32'(m_ovf));
        check({ctx, ".underflow"}, 32'(underflow), 32'(m_unf));
        check({ctx, ".rdata"},     32'(rdata),     32'(m_rdata));
    endtask

    // One clock of stimulus on the standard-mode instance, then model update and check.
    task automatic step(input logic w, input logic r, input logic f,
                        input logic [DW-1:0] d, input string ctx);
        logic wa, ra;
        @(negedge clk);
        winc = w; rinc = r; flush = f; wdata = d;
        @(posedge clk);
        wa = w && (m_count != 16);
        ra = r && (m_count != 0);
        if (f) begin
            m_count = 0; m_ovf = 1'b0; m_unf = 1'b0;
            sb_q.delete();
        end else begin
            if (w && m_count == 16) m_ovf = 1'b1;
            if (r && m_count == 0)  m_unf = 1'b1;
            if (ra) m_rdata = sb_q.pop_front();
            if (wa) sb_q.push_back(d);
            m_count = m_count + int'(wa) - int'(ra);
        end
        #1;
        check_all(ctx);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        flush = 1'b0; winc = 1'b0; rinc = 1'b0; wdata = '0;
        f_flush = 1'b0; f_winc = 1'b0; f_rinc = 1'b0; f_wdata = '0;
        #1 rst = 1'b1;
        #1 check_all("reset");
        @(negedge clk) rst = 1'b0;

        // FWFT instance: head word visible without a read request
        @(negedge clk) begin f_winc = 1'b1; f_wdata = 8'hA5; end
        @(posedge clk) #1;
        check("fwft.rempty", 32'(f_rempty), 32'd0);
        check("fwft.rdata",  32'(f_rdata),  32'hA5);
        @(negedge clk) f_winc = 1'b0;
        @(posedge clk) #1;
        check("fwft.hold_rdata", 32'(f_rdata), 32'hA5);
        check("fwft.count",      32'(f_count), 32'd1);
        @(negedge clk) f_rinc = 1'b1;
        @(posedge clk) #1;
        check("fwft.pop_rempty", 32'(f_rempty), 32'd1);
        check("fwft.pop_count",  32'(f_count),  32'd0);
        check("fwft.flags", 32'({f_wfull, f_walmost_full, f_ralmost_empty, f_overflow, f_underflow}),
              32'b00100);
        @(negedge clk) f_rinc = 1'b0;

        // Fill to full, then one write too many
        for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 1'b0, DW'(i), "fill");
        step(1'b1, 1'b0, 1'b0, 8'h11, "ovf");

        // Drain, then one read too many
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, '0, "drain");
        step(1'b0, 1'b1, 1'b0, '0, "unf");

        // Continuous write+read at count 5 across two pointer wraps
        step(1'b0, 1'b0, 1'b1, '0, "flush0");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, DW'(8'h20 + i), "pre5");
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0, DW'(8'h30 + i), "stream");

        // Simultaneous write+read at full and at empty
        for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 1'b0, DW'(8'h60 + i), "refill");
        step(1'b1, 1'b1, 1'b0, 8'hEE, "full_wr_rd");
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, '0, "drain2");
        step(1'b1, 1'b1, 1'b0, 8'h77, "empty_wr_rd");

        // Flush beats a concurrent write; count 9 with overflow still set
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, DW'(8'h80 + i), "to9");
        step(1'b1, 1'b0, 1'b1, 8'h99, "flush_wr");
        step(1'b0, 1'b0, 1'b0, '0, "post_flush");
        step(1'b1, 1'b0, 1'b0, 8'h42, "wr_after_flush");
        step(1'b0, 1'b1, 1'b0, '0, "rd_after_flush");

        // Asynchronous reset in the middle of a write burst
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, DW'(8'hC0 + i), "burst");
        @(negedge clk) begin winc = 1'b1; wdata = 8'hCF; end
        #2 rst = 1'b1;
        m_count = 0; m_ovf = 1'b0; m_unf = 1'b0; m_rdata = '0;
        sb_q.delete();
        #1 check_all("async_rst");
        @(negedge clk) begin rst = 1'b0; winc = 1'b0; end
        step(1'b1, 1'b0, 1'b0, 8'h5A, "wr_after_rst");
        step(1'b0, 1'b1, 1'b0, '0, "rd_after_rst");
        step(1'b0, 1'b0, 1'b0, '0, "idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
